// File: rtl/maze_bfs_solver_p_if.sv
// Handshake bundle between the maze loader, the BFS solver and the path consumer.
// Ports: in_valid/maze (loader->solver); out_valid/out_x/out_y/out_last/
//        maze_not_valid/q_overflow/busy (solver->consumer); slave = solver side.
interface maze_bfs_solver_p_if #(
   parameter int N = 13
);
   localparam int CW = $clog2(N + 1);

   logic          in_valid;
   logic          maze;
   logic          out_valid;
   logic [CW-1:0] out_x;
   logic [CW-1:0] out_y;
   logic          out_last;
   logic          maze_not_valid;
   logic          q_overflow;
   logic          busy;

   modport master (
      output in_valid,
      output maze,
      input  out_valid,
      input  out_x,
      input  out_y,
      input  out_last,
      input  maze_not_valid,
      input  q_overflow,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  maze,
      output out_valid,
      output out_x,
      output out_y,
      output out_last,
      output maze_not_valid,
      output q_overflow,
      output busy
   );
endinterface

// File: rtl/maze_bfs_solver_p.sv
// BFS maze solver: loads an NxN maze serially, searches (1,1)->(N,N), streams the path.
// Ports: clk, rst_n (async active-low), bus (slave modport: maze in, path/status out).
module maze_bfs_solver_p #(
   parameter  int N      = 13,
   parameter  int QDEPTH = 32,
   localparam int CW     = $clog2(N + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   maze_bfs_solver_p_if.slave bus
);

   localparam int NN = N * N;
   localparam int IW = $clog2(NN);
   localparam int LW = $clog2(NN + 1);
   localparam int QW = $clog2(QDEPTH);

   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] LIM    = CW'(N);
   localparam logic [LW-1:0] NN_L   = LW'(NN);
   localparam logic [QW:0]   Q_FULL = (QW + 1)'(QDEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEARCH,
      S_TRACE,
      S_FAIL
   } state_t;

   state_t state, state_nxt;

   // maze map, visited set and the direction each cell was reached by
   logic [NN-1:0] wall;
   logic [NN-1:0] vis;
   logic [1:0]    par [NN];

   logic [LW-1:0] cnt;

   logic [CW-1:0] qx [QDEPTH];
   logic [CW-1:0] qy [QDEPTH];
   logic [QW-1:0] head;
   logic [QW-1:0] tail;
   logic [QW:0]   occ;

   // current cell; cur_ok=0 right after LOAD forces the first pop
   logic [CW-1:0] cx;
   logic [CW-1:0] cy;
   logic          cur_ok;
   logic          ovf;

   function automatic logic [IW-1:0] cidx(
      input logic [CW-1:0] x,
      input logic [CW-1:0] y
   );
      int t;
      t = (int'(y) - 1) * N + int'(x) - 1;
      return IW'(t);
   endfunction

   function automatic logic inr(
      input logic [CW-1:0] x,
      input logic [CW-1:0] y
   );
      return (x >= ONE) && (x <= LIM) && (y >= ONE) && (y <= LIM);
   endfunction

   // neighbour order: 0 LEFT, 1 UP, 2 RIGHT, 3 DOWN
   logic [CW-1:0] nx [4];
   logic [CW-1:0] ny [4];
   logic [3:0]    cand;
   logic          hit;
   logic [1:0]    dsel;
   logic [CW-1:0] sx;
   logic [CW-1:0] sy;
   logic [IW-1:0] sidx;
   logic          goal;
   logic          at_start;
   logic [1:0]    pd;
   logic [CW-1:0] px;
   logic [CW-1:0] py;
   logic          q_full;
   logic          q_empty;

   always_comb begin
      nx[0] = cx - ONE;
      ny[0] = cy;
      nx[1] = cx;
      ny[1] = cy - ONE;
      nx[2] = cx + ONE;
      ny[2] = cy;
      nx[3] = cx;
      ny[3] = cy + ONE;
      cand  = '0;
      for (int d = 0; d < 4; d++) begin
         if (cur_ok && inr(nx[d], ny[d])) begin
            cand[d] = !wall[cidx(nx[d], ny[d])]
                   && !vis[cidx(nx[d], ny[d])];
         end
      end
   end

   always_comb begin
      hit  = 1'b1;
      dsel = 2'd0;
      if (cand[0]) dsel = 2'd0;
      else if (cand[1]) dsel = 2'd1;
      else if (cand[2]) dsel = 2'd2;
      else if (cand[3]) dsel = 2'd3;
      else hit = 1'b0;
   end

   assign sx       = nx[dsel];
   assign sy       = ny[dsel];
   assign sidx     = cidx(sx, sy);
   assign goal     = (sx == LIM) && (sy == LIM);
   assign at_start = (cx == ONE) && (cy == ONE);
   assign q_full   = (occ == Q_FULL);
   assign q_empty  = (occ == '0);
   assign pd       = par[cidx(cx, cy)];

   // parent is one step against the direction the cell was reached by
   always_comb begin
      px = cx;
      py = cy;
      unique case (pd)
         2'd0:    px = cx + ONE;
         2'd1:    py = cy + ONE;
         2'd2:    px = cx - ONE;
         default: py = cy - ONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (bus.in_valid) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (cnt == NN_L) begin
               if (wall[0] || wall[NN-1]) state_nxt = S_FAIL;
               else                       state_nxt = S_SEARCH;
            end else if (!bus.in_valid) begin
               state_nxt = S_IDLE;
            end
         end
         S_SEARCH: begin
            if (hit) begin
               if (q_full)    state_nxt = S_FAIL;
               else if (goal) state_nxt = S_TRACE;
            end else if (q_empty) begin
               state_nxt = S_FAIL;
            end
         end
         S_TRACE: begin
            if (at_start) state_nxt = S_IDLE;
         end
         S_FAIL:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // control registers: load counter, queue pointers, current cell, overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         head   <= '0;
         tail   <= '0;
         occ    <= '0;
         cx     <= '0;
         cy     <= '0;
         cur_ok <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.in_valid) cnt <= LW'(1);
            end
            S_LOAD: begin
               if (cnt != NN_L) begin
                  if (bus.in_valid) cnt <= cnt + LW'(1);
               end else begin
                  head   <= '0;
                  tail   <= QW'(1);
                  occ    <= (QW + 1)'(1);
                  cur_ok <= 1'b0;
                  ovf    <= 1'b0;
               end
            end
            S_SEARCH: begin
               if (hit) begin
                  if (q_full) begin
                     ovf <= 1'b1;
                  end else begin
                     tail <= tail + QW'(1);
                     occ  <= occ + (QW + 1)'(1);
                     if (goal) begin
                        cx <= LIM;
                        cy <= LIM;
                     end
                  end
               end else if (!q_empty) begin
                  cx     <= qx[head];
                  cy     <= qy[head];
                  head   <= head + QW'(1);
                  occ    <= occ - (QW + 1)'(1);
                  cur_ok <= 1'b1;
               end
            end
            S_TRACE: begin
               cx <= px;
               cy <= py;
            end
            S_FAIL:  ovf <= 1'b0;
            default: ;
         endcase
      end
   end

   // storage arrays; no reset needed, every frame rewrites what it reads
   always_ff @(posedge clk) begin
      unique case (state)
         S_IDLE: begin
            if (bus.in_valid) wall[0] <= bus.maze;
         end
         S_LOAD: begin
            if (cnt != NN_L) begin
               if (bus.in_valid) wall[cnt[IW-1:0]] <= bus.maze;
            end else begin
               vis   <= NN'(1);
               qx[0] <= ONE;
               qy[0] <= ONE;
            end
         end
         S_SEARCH: begin
            if (hit && !q_full) begin
               vis[sidx] <= 1'b1;
               par[sidx] <= dsel;
               qx[tail]  <= sx;
               qy[tail]  <= sy;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid      <= 1'b0;
         bus.out_x          <= '0;
         bus.out_y          <= '0;
         bus.out_last       <= 1'b0;
         bus.maze_not_valid <= 1'b0;
         bus.q_overflow     <= 1'b0;
         bus.busy           <= 1'b0;
      end else begin
         bus.out_valid      <= 1'b0;
         bus.out_x          <= '0;
         bus.out_y          <= '0;
         bus.out_last       <= 1'b0;
         bus.maze_not_valid <= 1'b0;
         bus.q_overflow     <= 1'b0;
         bus.busy           <= (state_nxt == S_SEARCH)
                            || (state_nxt == S_TRACE)
                            || (state_nxt == S_FAIL);
         if (state == S_TRACE) begin
            bus.out_valid <= 1'b1;
            bus.out_x     <= cx;
            bus.out_y     <= cy;
            bus.out_last  <= at_start;
         end
         if (state == S_FAIL) begin
            bus.out_valid      <= 1'b1;
            bus.out_last       <= 1'b1;
            bus.maze_not_valid <= 1'b1;
            bus.q_overflow     <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_maze_bfs_solver_p.sv
// Scoreboard bench for maze_bfs_solver_p: N=4/QDEPTH=32 and N=13/QDEPTH=4 instances.
// Expected beats are queued by the stimulus; negedge monitors pop and compare.
module tb_maze_bfs_solver_p;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   maze_bfs_solver_p_if #(.N(4))  b4();
   maze_bfs_solver_p_if #(.N(13)) b13();

   maze_bfs_solver_p #(.N(4), .QDEPTH(32)) u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4.slave)
   );

   maze_bfs_solver_p #(.N(13), .QDEPTH(4)) u13 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b13.slave)
   );

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic       last;
      logic       mnv;
      logic       ovf;
   } beat_t;

   beat_t q4[$];
   beat_t q13[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    r4    = 0;
   bit    r13   = 0;

   function automatic void cmp_beat(string tag, beat_t a, beat_t e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s got x=%0d y=%0d last=%0d mnv=%0d ovf=%0d want x=%0d y=%0d last=%0d mnv=%0d ovf=%0d",
                  tag, a.x, a.y, a.last, a.mnv, a.ovf, e.x, e.y, e.last, e.mnv, e.ovf);
      end
   endfunction

   function automatic void chk(string tag, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endfunction

   function automatic beat_t mk(int x, int y, bit last, bit mnv, bit ovf);
      beat_t b;
      b.x    = 4'(x);
      b.y    = 4'(y);
      b.last = last;
      b.mnv  = mnv;
      b.ovf  = ovf;
      return b;
   endfunction

   // monitor for the N=4 instance
   initial forever begin
      beat_t a;
      @(negedge clk);
      if (!rst_n) begin
         r4 = 0;
      end else begin
         if (r4) begin
            n_cmp++;
            if (!b4.out_valid) begin
               n_bad++;
               $display("FAIL n4_gap out_valid=0 want 1");
               r4 = 0;
            end
         end
         if (b4.out_valid) begin
            a = mk(int'(b4.out_x), int'(b4.out_y), b4.out_last,
                   b4.maze_not_valid, b4.q_overflow);
            if (q4.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL n4_unexpected beat x=%0d y=%0d want none", a.x, a.y);
            end else begin
               cmp_beat("n4_beat", a, q4.pop_front());
            end
            r4 = !b4.out_last;
         end
      end
   end

   // monitor for the N=13 instance
   initial forever begin
      beat_t a;
      @(negedge clk);
      if (!rst_n) begin
         r13 = 0;
      end else begin
         if (r13) begin
            n_cmp++;
            if (!b13.out_valid) begin
               n_bad++;
               $display("FAIL n13_gap out_valid=0 want 1");
               r13 = 0;
            end
         end
         if (b13.out_valid) begin
            a = mk(int'(b13.out_x), int'(b13.out_y), b13.out_last,
                   b13.maze_not_valid, b13.q_overflow);
            if (q13.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL n13_unexpected beat x=%0d y=%0d want none", a.x, a.y);
            end else begin
               cmp_beat("n13_beat", a, q13.pop_front());
            end
            r13 = !b13.out_last;
         end
      end
   end

   task automatic send(input int which, input bit m[$], input int nb);
      for (int i = 0; i < nb; i++) begin
         @(posedge clk);
         #1;
         if (which == 4) begin
            b4.in_valid = 1'b1;
            b4.maze     = m[i];
         end else begin
            b13.in_valid = 1'b1;
            b13.maze     = m[i];
         end
      end
      @(posedge clk);
      #1;
      b4.in_valid  = 1'b0;
      b4.maze      = 1'b0;
      b13.in_valid = 1'b0;
      b13.maze     = 1'b0;
   endtask

   task automatic drain(input int which, input int budget);
      int c;
      int left;
      c    = 0;
      left = (which == 4) ? q4.size() : q13.size();
      while (left != 0 && c < budget) begin
         @(posedge clk);
         c++;
         left = (which == 4) ? q4.size() : q13.size();
      end
      if (left != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain%0d_timeout outstanding=%0d want 0", which, left);
         if (which == 4) q4.delete();
         else            q13.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic push_open4();
      int px[7] = '{4, 4, 4, 4, 3, 2, 1};
      int py[7] = '{4, 3, 2, 1, 1, 1, 1};
      for (int i = 0; i < 7; i++)
         q4.push_back(mk(px[i], py[i], i == 6, 1'b0, 1'b0));
   endtask

   initial begin
      bit m[$];
      int c;
      int cx[7] = '{4, 3, 2, 1, 1, 1, 1};
      int cy[7] = '{4, 4, 4, 4, 3, 2, 1};

      b4.in_valid  = 1'b0;
      b4.maze      = 1'b0;
      b13.in_valid = 1'b0;
      b13.maze     = 1'b0;

      #12;
      chk("rst_n4_out_valid", int'(b4.out_valid), 0);
      chk("rst_n4_busy", int'(b4.busy), 0);
      chk("rst_n13_out_valid", int'(b13.out_valid), 0);
      chk("rst_n13_out_x", int'(b13.out_x), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // N=4 fully open
      m.delete();
      for (int i = 0; i < 16; i++) m.push_back(1'b0);
      push_open4();
      send(4, m, 16);
      @(posedge clk);
      @(negedge clk);
      chk("n4_busy_search", int'(b4.busy), 1);
      drain(4, 500);

      // N=4 goal cell walled
      m.delete();
      for (int i = 0; i < 16; i++) m.push_back(i == 15);
      q4.push_back(mk(0, 0, 1'b1, 1'b1, 1'b0));
      send(4, m, 16);
      drain(4, 100);

      // N=4 row 2 walled off
      m.delete();
      for (int y = 1; y <= 4; y++)
         for (int x = 1; x <= 4; x++) m.push_back(y == 2);
      q4.push_back(mk(0, 0, 1'b1, 1'b1, 1'b0));
      send(4, m, 16);
      drain(4, 200);

      // N=13 fully open overflows the 4-entry queue
      m.delete();
      for (int i = 0; i < 169; i++) m.push_back(1'b0);
      q13.push_back(mk(0, 0, 1'b1, 1'b1, 1'b1));
      send(13, m, 169);
      drain(13, 1000);

      // N=13 corridor: row 1 then column 13
      m.delete();
      for (int y = 1; y <= 13; y++)
         for (int x = 1; x <= 13; x++) m.push_back(!(y == 1 || x == 13));
      for (int y = 13; y >= 1; y--) q13.push_back(mk(13, y, 1'b0, 1'b0, 1'b0));
      for (int x = 12; x >= 1; x--) q13.push_back(mk(x, 1, x == 1, 1'b0, 1'b0));
      send(13, m, 169);
      drain(13, 2000);

      // aborted frame, then a frame with column 2 walled in rows 1..3
      m.delete();
      for (int i = 0; i < 16; i++) m.push_back(1'b0);
      send(4, m, 7);
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", int'(b4.busy), 0);
      chk("abort_out_valid", int'(b4.out_valid), 0);
      m.delete();
      for (int y = 1; y <= 4; y++)
         for (int x = 1; x <= 4; x++) m.push_back(x == 2 && y <= 3);
      for (int i = 0; i < 7; i++) q4.push_back(mk(cx[i], cy[i], i == 6, 1'b0, 1'b0));
      send(4, m, 16);
      drain(4, 500);

      // reset in the middle of a trace
      m.delete();
      for (int i = 0; i < 16; i++) m.push_back(1'b0);
      push_open4();
      send(4, m, 16);
      c = 0;
      while (!b4.out_valid && c < 500) begin
         @(negedge clk);
         c++;
      end
      if (!b4.out_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL trace_start_timeout out_valid=0 want 1");
      end
      #2;
      rst_n = 1'b0;
      #1;
      q4.delete();
      chk("midrst_out_valid", int'(b4.out_valid), 0);
      chk("midrst_out_x", int'(b4.out_x), 0);
      chk("midrst_out_y", int'(b4.out_y), 0);
      chk("midrst_busy", int'(b4.busy), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);

      push_open4();
      send(4, m, 16);
      drain(4, 500);

      chk("final_q4_empty", q4.size(), 0);
      chk("final_q13_empty", q13.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
